// File: rtl/mem_d2c_loader.sv
// -----------------------------------------------------------------------------
// mem_d2c_loader
// Loads a block from DRAM into an on-chip memory. One load request is split
// into DMA read descriptors of at most MAX_BURST bytes. Each AXIS beat that
// comes back is unpacked into RATIO = AXIS_W/MEM_W memory words. The words are
// written one per cycle at consecutive word addresses, and the address wraps
// modulo MEM_DEPTH. A single done pulse follows the final word.
//
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start_pulse                  request strobe (ignored while busy)
//   i_d_addr / i_c_addr / i_n_bytes DDR byte address, memory word address, size
//   o_busy, o_done_pulse           request status
//   o_dma_rd_desc_*                descriptor channel (valid/ready)
//   i/o_dma_rd_read_data_*         AXIS read stream (tdata/tvalid/tready/tlast)
//   o_wr_en, o_wr_addr, o_din      memory write port (OUT_PIPE extra stages)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_pulse
// DESC   | presenting a descriptor, held until ready
// DATA   | accepting beats of the current descriptor, unpacking to words
// DONE   | one cycle; done_pulse follows in the next cycle
// -----------------------------------------------------------------------------
module mem_d2c_loader #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 20,
  parameter int AXIS_W    = 512,
  parameter int MEM_W     = 128,
  parameter int MEM_DEPTH = 4096,
  parameter int MAX_BURST = 4096,
  parameter int OUT_PIPE  = 0,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_pulse,
  input  logic [31:0]       i_d_addr,
  input  logic [31:0]       i_c_addr,
  input  logic [31:0]       i_n_bytes,
  output logic              o_busy,
  output logic              o_done_pulse,
  output logic [ADDR_W-1:0] o_dma_rd_desc_addr,
  output logic [LEN_W-1:0]  o_dma_rd_desc_len,
  output logic              o_dma_rd_desc_valid,
  input  logic              i_dma_rd_desc_ready,
  input  logic [AXIS_W-1:0] i_dma_rd_read_data_tdata,
  input  logic              i_dma_rd_read_data_tvalid,
  output logic              o_dma_rd_read_data_tready,
  input  logic              i_dma_rd_read_data_tlast,
  output logic              o_wr_en,
  output logic [AW-1:0]     o_wr_addr,
  output logic [MEM_W-1:0]  o_din
);

  localparam int RATIO = AXIS_W / MEM_W;
  localparam int SUB_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DRN_W = 2;
  localparam int PW    = 1 + AW + MEM_W;

  typedef enum logic [1:0] {S_IDLE, S_DESC, S_DATA, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  // reset synchroniser: assertion is immediate, release is aligned to clk
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  logic [31:0]       r_rem;
  logic [ADDR_W-1:0] r_daddr;
  logic [AW-1:0]     r_caddr;
  logic              r_done;
  logic [DRN_W-1:0]  r_drain;

  // unpack stage: r_buf holds the remaining words of the current beat; its
  // low word is the word currently presented at stage 0
  logic [AXIS_W-1:0] r_buf;
  logic [SUB_W-1:0]  r_sub;
  logic              r_s0_en;
  logic [AW-1:0]     r_s0_addr;
  logic              r_last;

  logic [31:0] w_len32;
  logic        w_start_acc;
  logic        w_desc_hs;
  logic        w_draining;
  logic        w_tready;
  logic        w_beat_hs;
  logic        w_adv;
  logic        w_fin;
  logic [PW-1:0] w_s0;
  logic [PW-1:0] w_out;
  logic        w_unused_c;

  assign w_unused_c = &{1'b0, i_c_addr[31:AW]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_len32     = (r_rem > 32'(MAX_BURST)) ? 32'(MAX_BURST) : r_rem;
  assign w_start_acc = i_start_pulse && (r_state == S_IDLE) && !r_done;
  assign w_desc_hs   = (r_state == S_DESC) && i_dma_rd_desc_ready;
  assign w_draining  = (r_drain != '0);

  // a new beat is taken when stage 0 is empty or showing its last word
  assign w_tready  = (r_state == S_DATA) && !w_draining &&
                     (!r_s0_en || (r_sub == SUB_W'(RATIO-1)));
  assign w_beat_hs = w_tready && i_dma_rd_read_data_tvalid;
  assign w_adv     = r_s0_en && (r_sub != SUB_W'(RATIO-1));

  // true at the edge that loads the final word of a tlast beat into stage 0
  generate
    if (RATIO == 1) begin : g_fin_r1
      assign w_fin = w_beat_hs && i_dma_rd_read_data_tlast;
    end else begin : g_fin_rn
      assign w_fin = w_adv && r_last && (r_sub == SUB_W'(RATIO-2));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) w_state_nxt = (i_n_bytes == '0) ? S_DONE : S_DESC;
      end
      S_DESC: begin
        if (i_dma_rd_desc_ready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_draining) begin
          if (r_drain == DRN_W'(1)) w_state_nxt = S_DONE;
        end else if (w_fin) begin
          if (r_rem != '0)        w_state_nxt = S_DESC;
          else if (OUT_PIPE == 0) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rem   <= '0;
      r_daddr <= '0;
      r_done  <= 1'b0;
      r_drain <= '0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_start_acc) begin
        r_rem   <= i_n_bytes;
        r_daddr <= ADDR_W'(i_d_addr);
      end else if (w_desc_hs) begin
        r_rem   <= r_rem - w_len32;
        r_daddr <= r_daddr + ADDR_W'(w_len32);
      end
      // hold DONE back until the last word has left the output pipeline
      if ((r_state == S_DATA) && w_fin && (r_rem == '0) && (OUT_PIPE != 0))
        r_drain <= DRN_W'(OUT_PIPE);
      else if (w_draining)
        r_drain <= r_drain - DRN_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_caddr   <= '0;
      r_buf     <= '0;
      r_sub     <= '0;
      r_s0_en   <= 1'b0;
      r_s0_addr <= '0;
      r_last    <= 1'b0;
    end else begin
      if (w_start_acc) r_caddr <= i_c_addr[AW-1:0];
      if (w_beat_hs) begin
        r_buf     <= i_dma_rd_read_data_tdata;
        r_sub     <= '0;
        r_s0_en   <= 1'b1;
        r_last    <= i_dma_rd_read_data_tlast;
        r_s0_addr <= r_caddr;
        r_caddr   <= r_caddr + AW'(1);
      end else if (w_adv) begin
        r_buf     <= r_buf >> MEM_W;
        r_sub     <= r_sub + SUB_W'(1);
        r_s0_addr <= r_caddr;
        r_caddr   <= r_caddr + AW'(1);
      end else begin
        r_s0_en <= 1'b0;
      end
    end
  end

  assign w_s0 = {r_s0_en, r_s0_addr, r_buf[MEM_W-1:0]};

  generate
    if (OUT_PIPE == 0) begin : g_nopipe
      assign w_out = w_s0;
    end else begin : g_pipe
      logic [PW-1:0] r_pipe [OUT_PIPE];
      always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          for (int i = 0; i < OUT_PIPE; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_s0;
          for (int i = 1; i < OUT_PIPE; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_out = r_pipe[OUT_PIPE-1];
    end
  endgenerate

  assign o_wr_en   = w_out[PW-1];
  assign o_wr_addr = w_out[MEM_W +: AW];
  assign o_din     = w_out[MEM_W-1:0];

  assign o_busy                    = (r_state != S_IDLE) || r_done;
  assign o_done_pulse              = r_done;
  assign o_dma_rd_desc_valid       = (r_state == S_DESC);
  assign o_dma_rd_desc_addr        = (r_state == S_DESC) ? r_daddr : '0;
  assign o_dma_rd_desc_len         = (r_state == S_DESC) ? LEN_W'(w_len32) : '0;
  assign o_dma_rd_read_data_tready = w_tready;

endmodule

// File: tb/tb_mem_d2c_loader.sv
module tb_mem_d2c_loader;
  localparam int ADDR_W = 32, LEN_W = 20, AXIS_W = 512, MEM_W = 128;
  localparam int MEM_DEPTH = 4096, AW = 12, MAX_BURST = 4096, BEAT_B = AXIS_W / 8;
  localparam int RATIO = AXIS_W / MEM_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] d_addr = '0, c_addr = '0, n_bytes = '0;
  logic busy, done_pulse;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0] desc_len;
  logic desc_valid;
  logic desc_ready = 1'b0;
  logic [AXIS_W-1:0] tdata = '0;
  logic tvalid = 1'b0, tlast = 1'b0;
  logic tready;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [MEM_W-1:0] din;

  always #5 clk = ~clk;

  mem_d2c_loader #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .AXIS_W(AXIS_W), .MEM_W(MEM_W),
    .MEM_DEPTH(MEM_DEPTH), .MAX_BURST(MAX_BURST), .OUT_PIPE(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_pulse(start),
    .i_d_addr(d_addr), .i_c_addr(c_addr), .i_n_bytes(n_bytes),
    .o_busy(busy), .o_done_pulse(done_pulse),
    .o_dma_rd_desc_addr(desc_addr), .o_dma_rd_desc_len(desc_len),
    .o_dma_rd_desc_valid(desc_valid), .i_dma_rd_desc_ready(desc_ready),
    .i_dma_rd_read_data_tdata(tdata), .i_dma_rd_read_data_tvalid(tvalid),
    .o_dma_rd_read_data_tready(tready), .i_dma_rd_read_data_tlast(tlast),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_din(din)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int desc_seen = 0;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [MEM_W-1:0] data;
  } wr_t;
  wr_t sb_q[$];
  wr_t mon_e;

  typedef struct {
    logic [31:0] d, c, n;
    int rdly;
    bit gaps;
    bit dup;
    int exp_desc;
    int exp_wr;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // write scoreboard: every word on the memory port must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected got addr=%0d", wr_addr);
        end else begin
          mon_e = sb_q.pop_front();
          if (wr_addr !== mon_e.addr || din !== mon_e.data) begin
            errors++;
            $display("FAIL wr_word got addr=%0d data=%h exp addr=%0d data=%h",
                     wr_addr, din, mon_e.addr, mon_e.data);
          end
        end
      end
      if (done_pulse) done_cnt++;
    end
  end

  task automatic run_req(input logic [31:0] d, input logic [31:0] c, input logic [31:0] n,
                         input int rdly, input bit gaps, input bit dup);
    logic [31:0] rem, da, len;
    logic [AW-1:0] ca;
    logic [AXIS_W-1:0] beat;
    logic [ADDR_W-1:0] a0;
    logic [LEN_W-1:0] l0;
    bit stable;
    int t, nb;
    @(negedge clk);
    d_addr = d; c_addr = c; n_bytes = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    rem = n; da = d; ca = c[AW-1:0];
    while (rem != 0) begin
      len = (rem > MAX_BURST) ? MAX_BURST : rem;
      t = 0;
      while (!desc_valid && t < 200) begin @(negedge clk); t++; end
      chk("desc_valid_seen", desc_valid, 1);
      if (!desc_valid) return;
      a0 = desc_addr; l0 = desc_len; stable = 1;
      repeat (rdly) begin
        @(negedge clk);
        if (!desc_valid || desc_addr !== a0 || desc_len !== l0 || tready) stable = 0;
      end
      chk("desc_stable", stable, 1);
      chk("desc_addr", desc_addr, da);
      chk("desc_len", desc_len, len);
      desc_ready = 1'b1;
      @(negedge clk);
      desc_ready = 1'b0;
      desc_seen++;
      if (dup) begin
        n_bytes = 32'd64; d_addr = 32'hdead0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      da = da + len; rem = rem - len;
      nb = len / BEAT_B;
      for (int b = 0; b < nb; b++) begin
        for (int w = 0; w < AXIS_W / 32; w++) beat[w*32 +: 32] = $urandom;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        tdata = beat; tlast = (b == nb - 1); tvalid = 1'b1;
        t = 0;
        while (!tready && t < 50) begin @(negedge clk); t++; end
        if (!tready) begin
          chk("beat_accept_timeout", 0, 1);
          tvalid = 1'b0;
          return;
        end
        for (int k = 0; k < RATIO; k++) begin
          sb_q.push_back('{ca, beat[k*MEM_W +: MEM_W]});
          ca = ca + 1'b1;
        end
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
      end
    end
    t = 0;
    while (!done_pulse && t < 100) begin @(negedge clk); t++; end
    chk("done_seen", done_pulse, 1);
    @(negedge clk);
    chk("busy_clear", busy, 0);
    chk("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    int d0, w0, s0, t;
    bit no_desc;
    vt[0] = '{32'h0000_1000, 32'd10,   32'd128,   0,  1'b0, 1'b0, 1, 8};
    vt[1] = '{32'h0002_0000, 32'd100,  32'd10240, 0,  1'b0, 1'b0, 3, 640};
    vt[2] = '{32'h0000_0040, 32'd4094, 32'd64,    0,  1'b0, 1'b0, 1, 4};
    vt[3] = '{32'h0000_8000, 32'd50,   32'd512,   20, 1'b1, 1'b1, 1, 32};
    vt[4] = '{32'h0000_0100, 32'd4000, 32'd8384,  3,  1'b1, 1'b0, 3, 524};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_tready", tready, 0);
    chk("rst_wr_en", wr_en, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vt[i]) begin
      d0 = done_cnt; w0 = wr_cnt; s0 = desc_seen;
      run_req(vt[i].d, vt[i].c, vt[i].n, vt[i].rdly, vt[i].gaps, vt[i].dup);
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d_desc_count", i), desc_seen - s0, vt[i].exp_desc);
      chk($sformatf("vec%0d_write_count", i), wr_cnt - w0, vt[i].exp_wr);
      chk($sformatf("vec%0d_done_count", i), done_cnt - d0, 1);
    end

    // zero-length request with start held through busy and done cycles
    d0 = done_cnt; no_desc = 1;
    @(negedge clk);
    n_bytes = 0; start = 1'b1;
    @(negedge clk);
    if (desc_valid) no_desc = 0;
    chk("zero_busy_c1", busy, 1);
    chk("zero_done_c1", done_pulse, 0);
    @(negedge clk);
    if (desc_valid) no_desc = 0;
    chk("zero_done_c2", done_pulse, 1);
    chk("zero_busy_c2", busy, 1);
    @(negedge clk);
    start = 1'b0;
    chk("zero_busy_after", busy, 0);
    repeat (10) begin
      @(negedge clk);
      if (desc_valid) no_desc = 0;
    end
    chk("zero_no_desc", no_desc, 1);
    chk("zero_done_count", done_cnt - d0, 1);

    // reset in the middle of a transfer
    @(negedge clk);
    d_addr = 32'h100; c_addr = 0; n_bytes = 256; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!desc_valid && t < 20) begin @(negedge clk); t++; end
    chk("mid_desc_valid", desc_valid, 1);
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    for (int w = 0; w < AXIS_W / 32; w++) tdata[w*32 +: 32] = $urandom;
    tvalid = 1'b1;
    chk("mid_tready", tready, 1);
    for (int k = 0; k < RATIO; k++) sb_q.push_back('{AW'(k), tdata[k*MEM_W +: MEM_W]});
    @(negedge clk);
    tvalid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_din", din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tready", tready, 0);
    chk("mid_rst_desc_valid", desc_valid, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    d0 = done_cnt; w0 = wr_cnt;
    run_req(32'h3000, 32'd7, 32'd192, 2, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("post_rst_writes", wr_cnt - w0, 12);
    chk("post_rst_done", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
